// File: rtl/axis_framer_pkg.sv
// Shared definitions for the AXI4-Stream framer.
// - state_e        : framer state encoding (IDLE / LOAD / SEND)
// - clog2()        : constant ceiling-log2 used to size pointers and counters
// - TKEEP_ALL_ONES : source of the all-ones TKEEP value, sliced to the bus width
package axis_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Wide enough for data buses up to 512 bits.
  localparam int                    MAX_KEEP_W     = 64;
  localparam logic [MAX_KEEP_W-1:0] TKEEP_ALL_ONES = '1;

endpackage

// File: rtl/axis_framer_m_fifo.sv
// Single-clock count-based FIFO with first-word-fall-through output.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointers and count only)
//   din, wr_en : write port; a write while full is ignored
//   full       : count == DEPTH
//   dout       : head-of-queue word, valid whenever !empty
//   rd_en      : pop the head word; ignored while empty
//   empty      : count == 0
//   count      : words stored
module sync_fifo_fwft
  import axis_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr_en,
  output logic                    full,
  output logic [DATA_WIDTH-1:0]   dout,
  input  logic                    rd_en,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Storage is not reset so it can map onto RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/axis_framer_m.sv
// FIFO-fed AXI4-Stream master that cuts buffered words into TLAST frames.
// Ports:
//   m_axis_aclk, m_axis_aresetn : clock, async active-low reset
//   din, wr_en, full            : producer write port
//   fill_level                  : words currently buffered
//   overflow                    : sticky, a write hit a full FIFO
//   cfg_frame_len, cfg_timeout  : frame length (beats), partial timeout (0 = off)
//   flush                       : pulse, release buffered words as a short frame
//   busy, frame_cnt             : frame in progress, frames completed
//   m_axis_*                    : AXI4-Stream master
//
// state | meaning
// IDLE  | waiting for a full frame, a flush or a timeout
// LOAD  | first word moves from FIFO head into the output register
// SEND  | presenting beats; each handshake reloads the next word
module axis_framer_m
  import axis_framer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4096,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                        m_axis_aclk,
  input  logic                        m_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        wr_en,
  output logic                        full,
  output logic [clog2(FIFO_DEPTH):0]  fill_level,
  output logic                        overflow,
  input  logic [LEN_WIDTH-1:0]        cfg_frame_len,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
  input  logic                        flush,
  output logic                        busy,
  output logic [31:0]                 frame_cnt,
  output logic                        m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);

  localparam int FILL_W = clog2(FIFO_DEPTH) + 1;

  state_e                   state_q, state_d;
  logic [FILL_W-1:0]        beats_left_q, beats_left_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic                     overflow_q, overflow_d;
  logic [31:0]              frame_cnt_q, frame_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     flush_pending_q, flush_pending_d;

  logic [DATA_WIDTH-1:0]    fifo_dout;
  logic                     fifo_rd_en, fifo_empty, fifo_full;
  logic [FILL_W-1:0]        fill;
  logic [FILL_W-1:0]        len_eff;
  logic                     timer_expired, start_ok, frame_start;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (m_axis_aclk),
    .rst_n (m_axis_aresetn),
    .din   (din),
    .wr_en (wr_en),
    .full  (fifo_full),
    .dout  (fifo_dout),
    .rd_en (fifo_rd_en),
    .empty (fifo_empty),
    .count (fill)
  );

  always_comb begin
    if (cfg_frame_len == '0)                          len_eff = FILL_W'(1);
    else if (32'(cfg_frame_len) > 32'(FIFO_DEPTH))    len_eff = FILL_W'(FIFO_DEPTH);
    else                                              len_eff = FILL_W'(cfg_frame_len);
  end

  // >= rather than == so a timeout lowered below the running count still fires.
  assign timer_expired = (cfg_timeout != '0) && (timer_q >= cfg_timeout);
  assign start_ok      = (fill >= len_eff) ||
                         ((flush_pending_q || timer_expired) && !fifo_empty);

  always_comb begin
    state_d         = state_q;
    beats_left_d    = beats_left_q;
    tvalid_d        = tvalid_q;
    tlast_d         = tlast_q;
    tdata_d         = tdata_q;
    frame_cnt_d     = frame_cnt_q;
    timer_d         = timer_q;
    flush_pending_d = flush_pending_q;
    overflow_d      = overflow_q | (wr_en & fifo_full);
    fifo_rd_en      = 1'b0;
    frame_start     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          frame_start  = 1'b1;
          beats_left_d = (fill < len_eff) ? fill : len_eff;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fifo_rd_en = 1'b1;
        tdata_d    = fifo_dout;
        tvalid_d   = 1'b1;
        tlast_d    = (beats_left_q == FILL_W'(1));
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (beats_left_q == FILL_W'(1)) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = ST_IDLE;
          end else begin
            // Every beat of the frame was buffered at start, so the head is valid.
            fifo_rd_en   = 1'b1;
            tdata_d      = fifo_dout;
            beats_left_d = beats_left_q - 1'b1;
            tlast_d      = (beats_left_q == FILL_W'(2));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start || fifo_empty || (cfg_timeout == '0)) begin
      timer_d = '0;
    end else if ((state_q == ST_IDLE) && (fill < len_eff) && !timer_expired) begin
      timer_d = timer_q + 1'b1;
    end

    // A pulse coinciding with a frame start is kept for the following frame.
    if (frame_start || ((state_q == ST_IDLE) && fifo_empty)) flush_pending_d = 1'b0;
    if (flush) flush_pending_d = 1'b1;
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q         <= ST_IDLE;
      beats_left_q    <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tdata_q         <= '0;
      overflow_q      <= 1'b0;
      frame_cnt_q     <= '0;
      timer_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      tdata_q         <= tdata_d;
      overflow_q      <= overflow_d;
      frame_cnt_q     <= frame_cnt_d;
      timer_q         <= timer_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign full          = fifo_full;
  assign fill_level    = fill;
  assign overflow      = overflow_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_cnt     = frame_cnt_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = TKEEP_ALL_ONES[DATA_WIDTH/8-1:0];

endmodule

// File: tb/tb_axis_framer_m.sv
module tb_axis_framer_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din = '0;
  logic        wr_en = 1'b0;
  logic        full;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] cfg_len = 16'd8;
  logic [15:0] cfg_tmo = 16'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] frame_cnt;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tready = 1'b0;

  int          rdy_mode = 1;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          beats_seen = 0;
  int          exp_frames = 0;
  logic [31:0] next_word = 32'd1;
  logic [31:0] exp_data[$];
  bit          exp_last[$];

  axis_framer_m #(
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (16),
    .LEN_WIDTH     (16),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .din            (din),
    .wr_en          (wr_en),
    .full           (full),
    .fill_level     (fill),
    .overflow       (overflow),
    .cfg_frame_len  (cfg_len),
    .cfg_timeout    (cfg_tmo),
    .flush          (flush),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .m_axis_tvalid  (tvalid),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tlast   (tlast),
    .m_axis_tready  (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Beat monitor: scoreboard compare on handshakes, stability check on stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(tvalid), 64'd1);
        check("stall_data", 64'(tdata), 64'(prev_data));
        check("stall_last", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_data.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got data %0h, expected no beat", tdata);
        end else begin
          check("beat_data", 64'(tdata), 64'(exp_data.pop_front()));
          check("beat_last", 64'(tlast), 64'(exp_last.pop_front()));
        end
        beats_seen++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic push_frame(input int len);
    for (int i = 0; i < len; i++) exp_last.push_back(i == len - 1);
    exp_frames++;
  endtask

  // Producer honouring full; data is a running sequence number.
  task automatic write_words(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(posedge clk); #1;
      if (full) begin
        wr_en = 1'b0;
      end else begin
        wr_en = 1'b1;
        din   = next_word;
        exp_data.push_back(next_word);
        next_word++;
        i++;
      end
      guard++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("write_budget", 64'(i), 64'(n));
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_data.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("drain_left", 64'(exp_data.size()), 64'd0);
  endtask

  task automatic wait_tvalid(input int budget);
    int c = 0;
    while (!tvalid && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("tvalid_seen", 64'(tvalid), 64'd1);
  endtask

  typedef struct {
    int len;
    int nwords;
    int tmo;
    bit do_flush;
    int pre_wait;
    int pre_beats;
    int f0;
    int f1;
    int f2;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int b0;
    int early;

    vecs[0] = '{len: 8,   nwords: 16, tmo: 0,  do_flush: 0, pre_wait: 0,  pre_beats: 0, f0: 8,  f1: 8, f2: 0};
    vecs[1] = '{len: 4,   nwords: 12, tmo: 0,  do_flush: 0, pre_wait: 0,  pre_beats: 0, f0: 4,  f1: 4, f2: 4};
    vecs[2] = '{len: 0,   nwords: 3,  tmo: 0,  do_flush: 0, pre_wait: 0,  pre_beats: 0, f0: 1,  f1: 1, f2: 1};
    vecs[3] = '{len: 100, nwords: 16, tmo: 0,  do_flush: 0, pre_wait: 0,  pre_beats: 0, f0: 16, f1: 0, f2: 0};
    vecs[4] = '{len: 8,   nwords: 5,  tmo: 0,  do_flush: 1, pre_wait: 10, pre_beats: 0, f0: 5,  f1: 0, f2: 0};
    vecs[5] = '{len: 8,   nwords: 3,  tmo: 20, do_flush: 0, pre_wait: 12, pre_beats: 0, f0: 3,  f1: 0, f2: 0};
    vecs[6] = '{len: 3,   nwords: 7,  tmo: 0,  do_flush: 1, pre_wait: 10, pre_beats: 6, f0: 3,  f1: 3, f2: 1};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("tkeep", 64'(tkeep), 64'hF);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven frame shapes, tready held high.
    for (int v = 0; v < NV; v++) begin
      cfg_len = 16'(vecs[v].len);
      cfg_tmo = 16'(vecs[v].tmo);
      b0 = beats_seen;
      if (vecs[v].f0 > 0) push_frame(vecs[v].f0);
      if (vecs[v].f1 > 0) push_frame(vecs[v].f1);
      if (vecs[v].f2 > 0) push_frame(vecs[v].f2);
      write_words(vecs[v].nwords);
      if (vecs[v].pre_wait > 0) begin
        repeat (vecs[v].pre_wait) @(posedge clk);
        #1;
        check($sformatf("v%0d_hold_beats", v), 64'(beats_seen - b0), 64'(vecs[v].pre_beats));
      end
      if (vecs[v].do_flush) pulse_flush();
      wait_drain(400);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("v%0d_fill", v), 64'(fill), 64'd0);
      check($sformatf("v%0d_frame_cnt", v), 64'(frame_cnt), 64'(exp_frames));
      check($sformatf("v%0d_last_left", v), 64'(exp_last.size()), 64'd0);
    end

    // Long timeout: 3 words sit for 100 cycles, then go out as one frame.
    cfg_len = 16'd8;
    cfg_tmo = 16'd100;
    push_frame(3);
    write_words(3);
    early = 0;
    repeat (97) begin
      @(posedge clk); #1;
      if (tvalid) early = 1;
    end
    check("tmo_no_early_valid", 64'(early), 64'd0);
    wait_drain(50);
    repeat (4) @(posedge clk);
    #1;
    check("tmo_fill", 64'(fill), 64'd0);
    check("tmo_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    cfg_tmo = 16'd0;

    // Flush while a full frame is being sent: leftover goes out right after.
    push_frame(8);
    push_frame(3);
    write_words(8);
    wait_tvalid(20);
    check("send_busy", 64'(busy), 64'd1);
    write_words(3);
    pulse_flush();
    wait_drain(60);
    repeat (4) @(posedge clk);
    #1;
    check("fsend_fill", 64'(fill), 64'd0);
    check("fsend_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Random back-pressure, two 16-beat frames.
    cfg_len = 16'd16;
    rdy_mode = 2;
    push_frame(16);
    push_frame(16);
    write_words(32);
    wait_drain(1500);
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1;
    check("rnd_fill", 64'(fill), 64'd0);
    check("rnd_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Overflow: frame loaded but stalled, FIFO refilled to 16, extra writes dropped.
    rdy_mode = 0;
    write_words(16);
    wait_tvalid(20);
    check("ovf_fill_after_load", 64'(fill), 64'd15);
    write_words(1);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_pre_flag", 64'(overflow), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      din   = 32'hDEAD_0000 + 32'(k);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_fill", 64'(fill), 64'd16);
    push_frame(16);
    push_frame(1);
    rdy_mode = 1;
    repeat (30) @(posedge clk);
    #1;
    check("ovf_fill_after_frame", 64'(fill), 64'd1);
    pulse_flush();
    wait_drain(50);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_drained_fill", 64'(fill), 64'd0);
    check("ovf_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Reset during beat 3 of an 8-beat frame.
    cfg_len = 16'd8;
    push_frame(8);
    b0 = beats_seen;
    write_words(8);
    begin
      int c = 0;
      while ((beats_seen - b0) < 2 && c < 50) begin
        @(posedge clk); #1;
        c++;
      end
    end
    check("rst_mid_beats", 64'(beats_seen - b0), 64'd2);
    check("rst_mid_valid_before", 64'(tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(tvalid), 64'd0);
    check("rst_mid_fill", 64'(fill), 64'd0);
    check("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_mid_overflow", 64'(overflow), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    exp_data.delete();
    exp_last.delete();
    exp_frames = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(8);
    write_words(8);
    wait_drain(60);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("post_rst_fill", 64'(fill), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
